rr_packet_arbiter: RTL and testbench

//   Round-robin output-port arbiter of the NoC router; answers the request lines driven by the arbiter BFM/input buffers.

---
 rtl/arbiter_pkg.sv | 26 ++
 rtl/rr_priority_sel.sv | 32 +++
 rtl/rr_packet_arbiter.sv | 107 ++++++++++
 tb/tb_rr_packet_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared NoC arbiter definitions: port indices, widths, FSM states and the index rotation helper.
package arbiter_pkg;

    localparam int unsigned NPORTS = 5;
    localparam int unsigned IDX_W  = 3;

    localparam logic [IDX_W-1:0] P_LOCAL = 3'd0;
    localparam logic [IDX_W-1:0] P_NORTH = 3'd1;
    localparam logic [IDX_W-1:0] P_EAST  = 3'd2;
    localparam logic [IDX_W-1:0] P_SOUTH = 3'd3;
    localparam logic [IDX_W-1:0] P_WEST  = 3'd4;

    // West was "last served" after reset, so Local heads the priority order
    localparam logic [IDX_W-1:0] RST_LAST = P_WEST;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Advance a port index by one, wrapping 4 -> 0 so only 0..4 ever appear
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == P_WEST) ? P_LOCAL : IDX_W'(idx + IDX_W'(1));
    endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// Combinational round-robin selector: first set request scanning from the port after last.
module rr_priority_sel
    import arbiter_pkg::*;
(
    input  logic [NPORTS-1:0] req,
    input  logic [IDX_W-1:0]  last,
    output logic              any,
    output logic [IDX_W-1:0]  sel_idx,
    output logic [NPORTS-1:0] sel_onehot
);

    logic [IDX_W-1:0] w_cur;

    always_comb begin
        any        = 1'b0;
        sel_idx    = '0;
        sel_onehot = '0;
        w_cur      = last;
        // last itself is visited on the fifth step, so it wins only as sole requester
        for (int k = 0; k < NPORTS; k++) begin
            w_cur = next_idx(w_cur);
            if (!any && req[w_cur]) begin
                any     = 1'b1;
                sel_idx = w_cur;
            end
        end
        if (any) begin
            sel_onehot = NPORTS'(1) << sel_idx;
        end
    end

endmodule

// File: rtl/rr_packet_arbiter.sv
// Round-robin packet arbiter for one NoC output port; holds a grant from header to tail.
module rr_packet_arbiter
    import arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NPORTS-1:0] req,
    input  logic              xfer,
    input  logic              tail,
    output logic [NPORTS-1:0] gnt,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              busy,
    output logic              proto_err
);

    arb_state_t        r_state;
    logic [NPORTS-1:0] r_gnt;
    logic [IDX_W-1:0]  r_gnt_idx;
    logic [IDX_W-1:0]  r_last;
    logic              r_busy;
    logic              r_proto_err;

    arb_state_t        w_state_nxt;
    logic [NPORTS-1:0] w_gnt_nxt;
    logic [IDX_W-1:0]  w_gnt_idx_nxt;
    logic [IDX_W-1:0]  w_last_nxt;
    logic              w_busy_nxt;

    logic [IDX_W-1:0]  w_last_arb;
    logic              w_release;
    logic              w_any;
    logic [IDX_W-1:0]  w_sel_idx;
    logic [NPORTS-1:0] w_sel_onehot;

    // On release the current port is already treated as last served, so re-arbitration needs no bubble
    assign w_last_arb = (r_state == GRANT) ? r_gnt_idx : r_last;
    assign w_release  = (xfer && tail) || !req[r_gnt_idx];

    rr_priority_sel u_sel (
        .req        (req),
        .last       (w_last_arb),
        .any        (w_any),
        .sel_idx    (w_sel_idx),
        .sel_onehot (w_sel_onehot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_last      <= RST_LAST;
            r_busy      <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_idx   <= w_gnt_idx_nxt;
            r_last      <= w_last_nxt;
            r_busy      <= w_busy_nxt;
            r_proto_err <= r_proto_err || (xfer && (r_state == IDLE));
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_idx_nxt = r_gnt_idx;
        w_last_nxt    = r_last;
        w_busy_nxt    = r_busy;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt   = GRANT;
                    w_gnt_nxt     = w_sel_onehot;
                    w_gnt_idx_nxt = w_sel_idx;
                    w_busy_nxt    = 1'b1;
                end
            end
            GRANT: begin
                // Tail and abort share one path: both mark the port served
                if (w_release) begin
                    w_last_nxt = r_gnt_idx;
                    if (w_any) begin
                        w_gnt_nxt     = w_sel_onehot;
                        w_gnt_idx_nxt = w_sel_idx;
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                        w_busy_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign busy      = r_busy;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Directed testbench for rr_packet_arbiter with hand-computed grant sequences.
module tb_rr_packet_arbiter;

    logic       clk;
    logic       rst;
    logic [4:0] req;
    logic       xfer;
    logic       tail;
    logic [4:0] gnt;
    logic [2:0] gnt_idx;
    logic       busy;
    logic       proto_err;

    int checks;
    int failures;

    rr_packet_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .xfer      (xfer),
        .tail      (tail),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .busy      (busy),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [4:0] exp_gnt,
                               input logic [2:0] exp_idx, input logic exp_busy);
        check_eq({tag, ".gnt"},  8'(gnt),     8'(exp_gnt));
        check_eq({tag, ".idx"},  8'(gnt_idx), 8'(exp_idx));
        check_eq({tag, ".busy"}, 8'(busy),    8'(exp_busy));
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 5'b0;
        xfer = 1'b0;
        tail = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [4:0] rr_seq [6];

    initial begin
        checks   = 0;
        failures = 0;
        rr_seq[0] = 5'b00001; rr_seq[1] = 5'b00010; rr_seq[2] = 5'b00100;
        rr_seq[3] = 5'b01000; rr_seq[4] = 5'b10000; rr_seq[5] = 5'b00001;

        // Reset state
        do_reset();
        check_grant("reset", 5'b0, 3'd0, 1'b0);
        check_eq("reset.err", 8'(proto_err), 8'd0);

        // Single Local packet of three flits
        req = 5'b00001;
        tick();
        check_grant("l_hdr", 5'b00001, 3'd0, 1'b1);
        xfer = 1'b1; tail = 1'b0;
        tick();
        check_grant("l_f1", 5'b00001, 3'd0, 1'b1);
        tick();
        check_grant("l_f2", 5'b00001, 3'd0, 1'b1);
        tail = 1'b1; req = 5'b0;
        tick();
        xfer = 1'b0; tail = 1'b0;
        check_grant("l_tail", 5'b0, 3'd0, 1'b0);
        check_eq("l_err", 8'(proto_err), 8'd0);

        // All five requesting with one-flit packets: full rotation, no idle cycle
        do_reset();
        req = 5'b11111;
        tick();
        check_grant("rr0", rr_seq[0], 3'd0, 1'b1);
        xfer = 1'b1; tail = 1'b1;
        for (int i = 1; i < 6; i++) begin
            tick();
            check_grant($sformatf("rr%0d", i), rr_seq[i], 3'(i % 5), 1'b1);
        end

        // Move last_served to North, then N and S request -> S wins, then N
        req = 5'b00010;
        tick();
        check_grant("to_n", 5'b00010, 3'd1, 1'b1);
        req = 5'b01010;
        tick();
        check_grant("ns_s", 5'b01000, 3'd3, 1'b1);
        req = 5'b00010;
        tick();
        check_grant("ns_n", 5'b00010, 3'd1, 1'b1);

        // East alone, back-to-back packets regranted without a bubble
        req = 5'b00100;
        tick();
        check_grant("e0", 5'b00100, 3'd2, 1'b1);
        tick();
        check_grant("e1", 5'b00100, 3'd2, 1'b1);
        tick();
        check_grant("e2", 5'b00100, 3'd2, 1'b1);

        // Grant West, abort it mid-packet, Local takes over; later arrivals do not preempt
        req = 5'b10000;
        tick();
        check_grant("w_gnt", 5'b10000, 3'd4, 1'b1);
        xfer = 1'b1; tail = 1'b0;
        tick();
        check_grant("w_body", 5'b10000, 3'd4, 1'b1);
        xfer = 1'b0; req = 5'b00001;
        tick();
        check_grant("abort_l", 5'b00001, 3'd0, 1'b1);
        req = 5'b11001; xfer = 1'b1;
        tick();
        check_grant("no_preempt0", 5'b00001, 3'd0, 1'b1);
        tick();
        check_grant("no_preempt1", 5'b00001, 3'd0, 1'b1);

        // Tail with no requesters left -> IDLE
        tail = 1'b1; req = 5'b0;
        tick();
        xfer = 1'b0; tail = 1'b0;
        check_grant("idle", 5'b0, 3'd0, 1'b0);
        check_eq("idle.err", 8'(proto_err), 8'd0);

        // Tail without xfer in IDLE is ignored; xfer in IDLE sets sticky error
        tail = 1'b1;
        tick();
        check_eq("tail_only.err", 8'(proto_err), 8'd0);
        tail = 1'b0; xfer = 1'b1;
        tick();
        check_eq("xfer_idle.err", 8'(proto_err), 8'd1);
        check_grant("xfer_idle", 5'b0, 3'd0, 1'b0);
        xfer = 1'b0;
        tick();
        tick();
        check_eq("err_sticky", 8'(proto_err), 8'd1);

        // Grant Local again (last served = Local, sole requester)
        req = 5'b00001;
        tick();
        check_grant("pre_rst", 5'b00001, 3'd0, 1'b1);

        // Asynchronous reset mid-GRANT drops grant before any clock edge
        #2;
        rst = 1'b1;
        #1;
        check_grant("async_rst", 5'b0, 3'd0, 1'b0);
        check_eq("async_rst.err", 8'(proto_err), 8'd0);
        tick();
        rst = 1'b0;
        req = 5'b11111;
        tick();
        check_grant("post_rst", 5'b00001, 3'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
